sdr_qsram_controller: RTL and testbench



---
 rtl/sdr_qsram_controller.sv | 148 ++++++++++++++
 tb/tb_sdr_qsram_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_qsram_controller.sv
// Host-side initiator for the SDR QSRAM: one outstanding single-word access at a time,
// strobe sequencing, tri-state data bus ownership and autonomous periodic refresh.
module sdr_qsram_controller #(
  parameter int ADDR_WIDTH       = 33,
  parameter int DATA_WIDTH       = 9,
  parameter int READ_LATENCY     = 2,
  parameter int REFRESH_INTERVAL = 780,
  parameter int REFRESH_CYCLES   = 4
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  HostReq,
  input  logic                  HostWrite,
  input  logic [ADDR_WIDTH-1:0] HostAddr,
  input  logic [DATA_WIDTH-1:0] HostWData,
  output logic                  HostReady,
  output logic                  HostRValid,
  output logic [DATA_WIDTH-1:0] HostRData,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic                  MemEnable,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  MemRefresh,
  inout  wire  [DATA_WIDTH-1:0] MemData,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ_CMD  = 3'd2,
    READ_WAIT = 3'd3,
    REFRESH   = 3'd4
  } state_t;

  localparam int WAIT_MAX = (READ_LATENCY > REFRESH_CYCLES) ? READ_LATENCY : REFRESH_CYCLES;
  localparam int WW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam int RW       = $clog2(REFRESH_INTERVAL);

  localparam logic [WW-1:0] RD_LOAD   = WW'(READ_LATENCY - 1);
  localparam logic [WW-1:0] RF_LOAD   = WW'(REFRESH_CYCLES - 1);
  localparam logic [RW-1:0] RF_RELOAD = RW'(REFRESH_INTERVAL - 1);

  state_t                state, next_state;
  logic [WW-1:0]         wait_cnt;
  logic [RW-1:0]         ref_cnt;
  logic                  pending;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  bus_drive;
  logic                  accept;

  // Handshake: a request transfers on a rising edge where HostReq && HostReady;
  // the host must hold HostWrite/HostAddr/HostWData stable while HostReq waits.
  assign HostReady = (state == IDLE) && !pending;
  assign accept    = HostReq && HostReady;
  assign dbg_state = state;

  // Bus enable decodes straight from the async-reset state, so reset releases it at once.
  assign MemData = bus_drive ? wdata_q : 'z;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    MemEnable  = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemRefresh = 1'b0;
    bus_drive  = 1'b0;
    case (state)
      IDLE: begin
        if (pending)      next_state = REFRESH;
        else if (HostReq) next_state = HostWrite ? WRITE : READ_CMD;
      end
      WRITE: begin
        MemEnable  = 1'b1;
        MemWrite   = 1'b1;
        bus_drive  = 1'b1;
        next_state = IDLE;
      end
      READ_CMD: begin
        MemEnable  = 1'b1;
        MemRead    = 1'b1;
        next_state = READ_WAIT;
      end
      READ_WAIT: begin
        if (wait_cnt == '0) next_state = IDLE;
      end
      REFRESH: begin
        MemEnable  = 1'b1;
        MemRefresh = 1'b1;
        if (wait_cnt == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch, shared wait counter and read capture.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      MemAddress <= '0;
      wdata_q    <= '0;
      wait_cnt   <= '0;
      HostRValid <= 1'b0;
      HostRData  <= '0;
    end else begin
      HostRValid <= 1'b0;
      if (accept) begin
        MemAddress <= HostAddr;
        wdata_q    <= HostWData;
      end
      case (state)
        IDLE:     wait_cnt <= RF_LOAD;
        READ_CMD: wait_cnt <= RD_LOAD;
        READ_WAIT: begin
          if (wait_cnt == '0) begin
            HostRData  <= MemData;
            HostRValid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end
        REFRESH: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - WW'(1);
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

  // Free-running refresh timer; a new expiry wins over the clear on REFRESH entry.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      ref_cnt <= RF_RELOAD;
      pending <= 1'b0;
    end else if (ref_cnt == '0) begin
      ref_cnt <= RF_RELOAD;
      pending <= 1'b1;
    end else begin
      ref_cnt <= ref_cnt - RW'(1);
      if (state == IDLE && pending) pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdr_qsram_controller.sv
// Bench for sdr_qsram_controller: memory device model on the shared bus, occupancy/refresh
// reference model and a scoreboard checking strobes, bus ownership, read data and refresh timing.
module tb_sdr_qsram_controller;
  localparam int AW  = 33;
  localparam int DW  = 9;
  localparam int L   = 2;
  localparam int INT = 16;
  localparam int RC  = 4;

  logic          Clock = 1'b0;
  logic          ResetN = 1'b0;
  logic          HostReq = 1'b0;
  logic          HostWrite = 1'b0;
  logic [AW-1:0] HostAddr = '0;
  logic [DW-1:0] HostWData = '0;
  logic          HostReady, HostRValid;
  logic [DW-1:0] HostRData;
  logic [AW-1:0] MemAddress;
  logic          MemEnable, MemRead, MemWrite, MemRefresh;
  logic [2:0]    dbg_state;
  wire  [DW-1:0] MemData;

  // Device read driver, plus a zero keeper on the idle bus so any stray controller drive is visible.
  logic          mem_drv = 1'b0;
  logic [DW-1:0] mem_val = '0;
  assign MemData = mem_drv ? mem_val : (!MemWrite ? '0 : 'z);

  sdr_qsram_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(L),
    .REFRESH_INTERVAL(INT), .REFRESH_CYCLES(RC)
  ) dut (
    .Clock(Clock), .ResetN(ResetN), .HostReq(HostReq), .HostWrite(HostWrite),
    .HostAddr(HostAddr), .HostWData(HostWData), .HostReady(HostReady),
    .HostRValid(HostRValid), .HostRData(HostRData), .MemAddress(MemAddress),
    .MemEnable(MemEnable), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemRefresh(MemRefresh), .MemData(MemData), .dbg_state(dbg_state)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int cyc;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[8:0] ^ a[32:24] ^ 9'h15A;
  endfunction

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } acc_t;

  acc_t          acc_q[$];
  logic [DW-1:0] exp_q[$];
  int            exp_t_q[$];
  int            ref_q[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] dev_mem [logic [AW-1:0]];
  logic [AW-1:0] pool [8];

  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Memory device: data appears on the bus L edges after the read-command cycle ends.
  int            rd_cnt = 0;
  logic [AW-1:0] rd_addr = '0;
  always @(posedge Clock) begin
    if (!ResetN) rd_cnt = 0;
    else begin
      if (MemEnable && MemWrite) dev_mem[MemAddress] = MemData;
      if (MemEnable && MemRead) begin
        rd_cnt  = L;
        rd_addr = MemAddress;
      end else if (rd_cnt > 0) rd_cnt--;
    end
    #1;
    mem_drv = (rd_cnt == 1);
    mem_val = dev_mem.exists(rd_addr) ? dev_mem[rd_addr] : init_val(rd_addr);
  end

  // Reference model, in edges since reset release: occupancy, refresh schedule, expected traffic.
  int busy_end = 0, pend_lo = 0, pend_hi = 0, n, s;
  bit ready_exp = 1'b1;
  always @(posedge Clock) begin
    if (ResetN && mon_en) begin
      n = cyc + 1;
      if (HostReq && HostReady) begin
        acc_q.push_back('{wr: HostWrite, addr: HostAddr, data: HostWData, cyc: n});
        if (HostWrite) begin
          ref_mem[HostAddr] = HostWData;
          busy_end = n + 1;
        end else begin
          exp_q.push_back(ref_mem.exists(HostAddr) ? ref_mem[HostAddr] : init_val(HostAddr));
          exp_t_q.push_back(n + 1 + L);
          busy_end = n + 1 + L;
        end
      end
      if (n % INT == 0) begin
        s = ((n > busy_end) ? n : busy_end) + 1;
        ref_q.push_back(s);
        pend_lo  = n;
        pend_hi  = s;
        busy_end = s + RC;
      end
      ready_exp = (n >= busy_end) && !(n >= pend_lo && n < pend_hi);
    end
  end

  // Monitor / scoreboard, sampled mid-cycle.
  acc_t a;
  bit   prev_ref = 1'b0;
  int   ref_len = 0;
  logic [DW-1:0] last_rdata = '0;
  always @(negedge Clock) begin
    if (ResetN && mon_en) begin
      if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
        a = acc_q.pop_front();
        chk("strobe_kind", {MemEnable, MemWrite, MemRead}, a.wr ? 3'b110 : 3'b101);
        chk("mem_addr", MemAddress, a.addr);
        if (a.wr) chk("write_data", MemData, a.data);
      end else if (MemRead || MemWrite) chk("unexpected_access", {MemRead, MemWrite}, 2'b00);

      if (exp_t_q.size() > 0 && exp_t_q[0] == cyc) begin
        chk("rvalid", HostRValid, 1'b1);
        chk("rdata", HostRData, exp_q[0]);
        last_rdata = exp_q.pop_front();
        void'(exp_t_q.pop_front());
      end else begin
        if (HostRValid) chk("unexpected_rvalid", HostRValid, 1'b0);
        chk("rdata_hold", HostRData, last_rdata);
      end

      if (ref_q.size() > 0 && ref_q[0] == cyc) begin
        chk("refresh_start", MemRefresh && !prev_ref, 1'b1);
        void'(ref_q.pop_front());
      end else if (MemRefresh && !prev_ref) chk("unexpected_refresh", 1'b1, 1'b0);
      if (MemRefresh) begin
        ref_len++;
        chk("refresh_enable", MemEnable, 1'b1);
      end else if (prev_ref) begin
        chk("refresh_len", ref_len, RC);
        ref_len = 0;
      end
      prev_ref = MemRefresh;

      chk("strobe_onehot", $onehot0({MemRead, MemWrite, MemRefresh}), 1'b1);
      chk("host_ready", HostReady, ready_exp);
      if (mem_drv)        chk("bus_read_data", MemData, mem_val);
      else if (!MemWrite) chk("bus_idle", MemData, '0);
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int t = 0;
    @(negedge Clock);
    HostReq = 1'b1; HostWrite = wr; HostAddr = addr; HostWData = data;
    while (!HostReady && t < 100) begin
      @(negedge Clock);
      t++;
    end
    chk("accept_timeout", t < 100, 1'b1);
    if (t < 100) @(posedge Clock);
    else HostReq = 1'b0;
  endtask

  task automatic idle(input int k);
    @(negedge Clock);
    HostReq = 1'b0;
    repeat (k - 1) @(negedge Clock);
  endtask

  initial begin
    int t;
    pool = '{33'h0_0000_0012, 33'h0_0000_0034, 33'h1_FFFF_FFFF, 33'h1_0000_0000,
             33'h0_8000_0001, 33'h0_ABCD_1234, 33'h1_5555_AAAA, 33'h0_0000_0000};
    ref_mem[33'h34] = 9'h0C3;
    dev_mem[33'h34] = 9'h0C3;

    // Reset held with a pending write request on the host side.
    HostReq = 1'b1; HostWrite = 1'b1; HostAddr = 33'h0_0000_0012; HostWData = 9'h1A5;
    mon_en = 1'b1;
    #12;
    chk("reset_strobes", {MemEnable, MemRead, MemWrite, MemRefresh}, 4'b0000);
    chk("reset_bus", MemData, '0);
    chk("reset_rvalid", HostRValid, 1'b0);
    chk("reset_rdata", HostRData, '0);
    chk("reset_addr", MemAddress, '0);
    @(negedge Clock);
    #2 ResetN = 1'b1;
    chk("ready_after_release", HostReady, 1'b1);
    @(posedge Clock);
    idle(3);

    issue(1'b0, 33'h34, '0);
    idle(6);

    for (int i = 0; i < 12; i++)
      issue(i % 2 == 0, pool[$urandom_range(0, 7)], DW'($urandom_range(0, 511)));
    idle(4);

    // Read accepted one edge before refresh goes pending, with the host still requesting.
    t = 0;
    do begin
      @(negedge Clock);
      t++;
    end while (cyc % INT != INT - 3 && t < 40);
    issue(1'b0, pool[1], '0);
    issue(1'b1, pool[2], DW'($urandom_range(0, 511)));
    idle(8);

    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
      issue($urandom_range(0, 1) == 1, pool[$urandom_range(0, 7)], DW'($urandom_range(0, 511)));
    end
    idle(20);
    chk("acc_overdue", acc_q.size() > 0 && acc_q[0].cyc <= cyc, 1'b0);
    chk("read_overdue", exp_t_q.size() > 0 && exp_t_q[0] <= cyc, 1'b0);
    chk("refresh_overdue", ref_q.size() > 0 && ref_q[0] <= cyc, 1'b0);

    // Reset asserted in the middle of a write cycle.
    mon_en = 1'b0;
    @(negedge Clock);
    HostReq = 1'b1; HostWrite = 1'b1; HostAddr = 33'h0_0000_0077; HostWData = 9'h1A5;
    t = 0;
    while (!HostReady && t < 100) begin
      @(negedge Clock);
      t++;
    end
    chk("mid_accept_timeout", t < 100, 1'b1);
    @(posedge Clock);
    #2 HostReq = 1'b0;
    chk("mid_write_strobe", MemWrite, 1'b1);
    chk("mid_write_bus", MemData, 9'h1A5);
    ResetN = 1'b0;
    #1;
    chk("mid_reset_bus", MemData, '0);
    chk("mid_reset_strobes", {MemEnable, MemRead, MemWrite, MemRefresh}, 4'b0000);
    chk("mid_reset_state", dbg_state, 3'd0);
    @(negedge Clock);
    ResetN = 1'b1;
    @(negedge Clock);
    chk("post_reset_ready", HostReady, 1'b1);
    chk("post_reset_rvalid", HostRValid, 1'b0);
    chk("post_reset_rdata", HostRData, '0);
    chk("post_reset_addr", MemAddress, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
